// File: rtl/root_tx_arbiter.sv
// Two-source round-robin injector for the root router port: each source owns a
// small packet FIFO with a saturating sent counter and a sticky overflow flag.

module root_tx_src #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 16,
    parameter int W          = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic [W-1:0]         tx_data,
    output logic                 rdy,
    input  logic                 pop,
    output logic [W-1:0]         head,
    output logic                 not_empty,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] sent_cnt,
    output logic                 ovf
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   occ;
    logic          push;

    assign rdy       = occ < (PW+1)'(FIFO_DEPTH);
    assign not_empty = occ != '0;
    assign head      = mem[rd_ptr];
    assign push      = tx_en & rdy;

    // Storage is left unreset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            sent_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (cnt_clear)
                sent_cnt <= '0;
            else if (pop && sent_cnt != '1)
                sent_cnt <= sent_cnt + 1'b1;
            if (cnt_clear)
                ovf <= 1'b0;
            else if (tx_en && !rdy)
                ovf <= 1'b1;
        end
    end
endmodule

module root_tx_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src0_tx_en,
    input  logic [35:0]          src0_tx_data,
    output logic                 src0_rdy,
    input  logic                 src1_tx_en,
    input  logic [35:0]          src1_tx_data,
    output logic                 src1_rdy,
    input  logic                 router_rdy,
    output logic                 out_tx_en,
    output logic [35:0]          out_tx_data,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] src0_sent_cnt,
    output logic [CNT_WIDTH-1:0] src1_sent_cnt,
    output logic                 src0_ovf,
    output logic                 src1_ovf
);
    localparam int NUM_SRC = 2;

    logic [NUM_SRC-1:0]                tx_en, rdy, pop, not_empty, ovf;
    logic [NUM_SRC-1:0][35:0]          tx_data, head;
    logic [NUM_SRC-1:0][CNT_WIDTH-1:0] sent_cnt;
    logic                              last_grant, gnt;

    assign tx_en   = {src1_tx_en, src0_tx_en};
    assign tx_data = {src1_tx_data, src0_tx_data};
    assign src0_rdy      = rdy[0];
    assign src1_rdy      = rdy[1];
    assign src0_sent_cnt = sent_cnt[0];
    assign src1_sent_cnt = sent_cnt[1];
    assign src0_ovf      = ovf[0];
    assign src1_ovf      = ovf[1];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        root_tx_src #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .CNT_WIDTH  (CNT_WIDTH),
            .W          (36)
        ) u_src (
            .clk       (clk),
            .rst       (rst),
            .tx_en     (tx_en[g]),
            .tx_data   (tx_data[g]),
            .rdy       (rdy[g]),
            .pop       (pop[g]),
            .head      (head[g]),
            .not_empty (not_empty[g]),
            .cnt_clear (cnt_clear),
            .sent_cnt  (sent_cnt[g]),
            .ovf       (ovf[g])
        );
    end

    // Tie goes to the source not served last; otherwise the only non-empty one.
    always_comb begin
        gnt = 1'b0;
        if (&not_empty)
            gnt = ~last_grant;
        else if (not_empty[1])
            gnt = 1'b1;
    end

    // Held low during reset so no stale head leaks out while queues are flushed.
    assign out_tx_en   = router_rdy & (|not_empty) & ~rst;
    assign out_tx_data = out_tx_en ? head[gnt] : '0;
    assign pop         = out_tx_en ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (out_tx_en)
            last_grant <= gnt;
    end
endmodule

// File: tb/tb_root_tx_arbiter.sv
// Randomized and directed stimulus for root_tx_arbiter, scored each cycle
// against a queue-based reference model of the arbitration rules.

module tb_root_tx_arbiter;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          src0_tx_en, src1_tx_en, router_rdy, cnt_clear;
    logic [35:0]   src0_tx_data, src1_tx_data;
    logic          src0_rdy, src1_rdy, out_tx_en, src0_ovf, src1_ovf;
    logic [35:0]   out_tx_data;
    logic [CW-1:0] src0_sent_cnt, src1_sent_cnt;

    always #5 clk = ~clk;

    root_tx_arbiter #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .src0_tx_en    (src0_tx_en),
        .src0_tx_data  (src0_tx_data),
        .src0_rdy      (src0_rdy),
        .src1_tx_en    (src1_tx_en),
        .src1_tx_data  (src1_tx_data),
        .src1_rdy      (src1_rdy),
        .router_rdy    (router_rdy),
        .out_tx_en     (out_tx_en),
        .out_tx_data   (out_tx_data),
        .cnt_clear     (cnt_clear),
        .src0_sent_cnt (src0_sent_cnt),
        .src1_sent_cnt (src1_sent_cnt),
        .src0_ovf      (src0_ovf),
        .src1_ovf      (src1_ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [35:0] q0[$], q1[$];
    logic        lg = 1'b1;
    int          c0 = 0, c1 = 0;
    logic        o0 = 1'b0, o1 = 1'b0;
    logic        last_g;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic e0, input logic [35:0] d0, input logic e1,
                         input logic [35:0] d1, input logic rr, input logic clr,
                         input logic rs);
        logic r0, r1, oe, g;
        logic [35:0] od;
        @(negedge clk);
        src0_tx_en = e0; src0_tx_data = d0;
        src1_tx_en = e1; src1_tx_data = d1;
        router_rdy = rr; cnt_clear = clr; rst = rs;
        #1;
        r0 = q0.size() < DEPTH;
        r1 = q1.size() < DEPTH;
        oe = rr && !rs && (q0.size() > 0 || q1.size() > 0);
        if (q0.size() > 0 && q1.size() > 0) g = ~lg;
        else g = (q0.size() == 0);
        od = oe ? (g ? q1[0] : q0[0]) : 36'h0;
        check("src0_rdy", 64'(src0_rdy), 64'(r0));
        check("src1_rdy", 64'(src1_rdy), 64'(r1));
        check("out_en", 64'(out_tx_en), 64'(oe));
        check("out_data", 64'(out_tx_data), 64'(od));
        check("cnt0", 64'(src0_sent_cnt), 64'(c0));
        check("cnt1", 64'(src1_sent_cnt), 64'(c1));
        check("ovf0", 64'(src0_ovf), 64'(o0));
        check("ovf1", 64'(src1_ovf), 64'(o1));
        last_g = oe ? g : 1'bx;
        @(posedge clk);
        if (rs) begin
            q0.delete(); q1.delete();
            lg = 1'b1; c0 = 0; c1 = 0; o0 = 1'b0; o1 = 1'b0;
        end else begin
            if (oe) begin
                if (g) begin void'(q1.pop_front()); if (c1 < CMAX) c1++; end
                else   begin void'(q0.pop_front()); if (c0 < CMAX) c0++; end
                lg = g;
            end
            if (e0) begin if (r0) q0.push_back(d0); else o0 = 1'b1; end
            if (e1) begin if (r1) q1.push_back(d1); else o1 = 1'b1; end
            if (clr) begin c0 = 0; c1 = 0; o0 = 1'b0; o1 = 1'b0; end
        end
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 36'h0, 1'b0, 36'h0, rr, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 36'h0, 1'b0, 36'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; router_rdy = 1'b0; cnt_clear = 1'b0;
        src0_tx_en = 1'b0; src1_tx_en = 1'b0;
        src0_tx_data = '0; src1_tx_data = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // tie: source 0 wins first, then source 1
        cycle(1'b1, 36'h4_0001_00AA, 1'b1, 36'h4_0002_00BB, 1'b1, 1'b0, 1'b0);
        #1 check("tie_first", 64'(out_tx_data), 64'h4_0001_00AA);
        idle(1'b1);
        #1 check("tie_second", 64'(out_tx_data), 64'h4_0002_00BB);
        idle(1'b1);
        idle(1'b1);

        // backpressure with overflow drop, then drain in order
        do_reset();
        cycle(1'b1, 36'h1_1111_0001, 1'b0, 36'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 36'h1_1111_0002, 1'b0, 36'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 36'h1_1111_0003, 1'b0, 36'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) idle(1'b1);
        #1 check("bp_cnt0", 64'(src0_sent_cnt), 64'd2);
        check("bp_ovf0", 64'(src0_ovf), 64'd1);

        // fairness: both queues kept busy
        do_reset();
        cycle(1'b1, 36'h2_0000_0000, 1'b1, 36'h3_0000_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++)
            cycle(1'b1, 36'h2_0000_0000 + 36'(i), 1'b1, 36'h3_0000_0000 + 36'(i),
                  1'b1, 1'b0, 1'b0);
        #1 check("fair_cnt0", 64'(src0_sent_cnt), 64'd4);
        check("fair_cnt1", 64'(src1_sent_cnt), 64'd4);

        // full source 1 with concurrent pop, then push+pop on one edge
        do_reset();
        cycle(1'b0, 36'h0, 1'b1, 36'h5_0000_0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 36'h0, 1'b1, 36'h5_0000_0002, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 36'h0, 1'b1, 36'h5_0000_0003, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 36'h0, 1'b1, 36'h5_0000_0004, 1'b1, 1'b0, 1'b0);
        repeat (3) idle(1'b1);

        // counter saturation, then clear racing a pop
        do_reset();
        for (int i = 0; i < 18; i++)
            cycle(1'b1, 36'h6_0000_0000 + 36'(i), 1'b0, 36'h0, 1'b1, 1'b0, 1'b0);
        #1 check("sat_cnt0", 64'(src0_sent_cnt), 64'(CMAX));
        cycle(1'b0, 36'h0, 1'b0, 36'h0, 1'b1, 1'b1, 1'b0);
        #1 check("clr_cnt0", 64'(src0_sent_cnt), 64'd0);

        // reset mid-stream discards queued packets
        cycle(1'b1, 36'h7_0000_0001, 1'b1, 36'h7_0000_0002, 1'b0, 1'b0, 1'b0);
        do_reset();
        repeat (3) idle(1'b1);
        #1 check("rst_out_en", 64'(out_tx_en), 64'd0);

        // random traffic
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom} & 36'hF_FFFF_FFFF,
                  1'($urandom_range(0, 1)), {$urandom, $urandom} & 36'hF_FFFF_FFFF,
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 99) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
